// File: rtl/stage_feed_pkg.sv
// Shared width helpers and default sizing for the stage feed FIFO.
package stage_feed_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_DEPTH = 16;
   localparam int unsigned PTR_W     = $clog2(DEF_DEPTH);
   localparam int unsigned LVL_W     = PTR_W + 1;

   typedef logic [LVL_W-1:0] level_t;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // Level needs one extra bit so that a full FIFO (level == DEPTH) is representable.
   function automatic int unsigned lvl_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/stage_feed_mem.sv
// DEPTH x WIDTH storage array with one write port and one registered read port.
module stage_feed_mem
   import stage_feed_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en_i,
   input  logic [ptr_w(DEPTH)-1:0]   wr_addr_i,
   input  logic [WIDTH-1:0]          wr_data_i,
   input  logic                      rd_en_i,
   input  logic [ptr_w(DEPTH)-1:0]   rd_addr_i,
   output logic [WIDTH-1:0]          rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Array contents are deliberately left unreset; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/stage_feed_fifo.sv
// Valid/ready buffered feed into an enable-pulsed register stage; drains one word per cycle.
module stage_feed_fifo
   import stage_feed_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     out_hold,
   output logic                     out_en,
   output logic [WIDTH-1:0]         out_d,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned LW = lvl_w(DEPTH);

   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q, level_d;
   logic          out_en_q;
   logic          overflow_q;
   logic          full, empty, push, pop;

   assign full     = (level_q == LW'(DEPTH));
   assign empty    = (level_q == '0);
   // No push-through when full: a same-cycle pop does not free a slot for this cycle's push.
   assign in_ready = !full && !flush;
   assign push     = in_valid && in_ready;
   assign pop      = !empty && !out_hold && !flush;

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         out_en_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else if (flush) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         out_en_q   <= 1'b0;
         overflow_q <= overflow_q | in_valid;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         level_q  <= level_d;
         out_en_q <= pop;
      end
   end

   stage_feed_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (push),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (in_data),
      .rd_en_i   (pop),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (out_d)
   );

   assign out_en   = out_en_q;
   assign level    = level_q;
   assign overflow = overflow_q;

endmodule
